// File: rtl/soc_pkg.sv
// Shared constants, FSM encodings and the hex font for the demo SoC board top.
package soc_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;
  localparam int NUM_BTN = 5;

  localparam int SCAN_IDX_W = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // Segment order {dp,g,f,e,d,c,b,a}; dp is never lit.
  function automatic logic [7:0] hex_font(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'h3F;
      4'h1: pat = 8'h06;
      4'h2: pat = 8'h5B;
      4'h3: pat = 8'h4F;
      4'h4: pat = 8'h66;
      4'h5: pat = 8'h6D;
      4'h6: pat = 8'h7D;
      4'h7: pat = 8'h07;
      4'h8: pat = 8'h7F;
      4'h9: pat = 8'h6F;
      4'hA: pat = 8'h77;
      4'hB: pat = 8'h7C;
      4'hC: pat = 8'h39;
      4'hD: pat = 8'h5E;
      4'hE: pat = 8'h79;
      default: pat = 8'h71;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/soc_uart_tx.sv
// 8N1 transmitter, BAUD_DIV cycles per bit; start is ignored while a frame is in flight.
// state | meaning: IDLE line high | START start bit | DATA 8 bits LSB-first | STOP stop bit
module soc_uart_tx
  import soc_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_DIV - 1);

  uart_state_t r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= UART_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        UART_IDLE: begin
          if (start) begin
            r_shift <= data;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_baud  <= BAUD_RELOAD;
            r_bit   <= '0;
            r_state <= UART_START;
          end
        end
        UART_START: begin
          if (r_baud == '0) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_baud  <= BAUD_RELOAD;
            r_state <= UART_DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        UART_DATA: begin
          if (r_baud == '0) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= UART_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        UART_STOP: begin
          if (r_baud == '0) begin
            r_busy  <= 1'b0;
            r_state <= UART_IDLE;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= UART_IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: rtl/soc_top.sv
// Board I/O top: button/switch conditioning, 32-bit display value, 7-seg scan, LEDs, UART.
// Optional transmitter is built only when SOC_UART_EN is defined.
module soc_top
  import soc_pkg::*;
#(
  parameter int IO_LED_WIDTH    = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_DIV        = 100_000,
  parameter int BAUD_DIV        = 868
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              btn,
  input  logic [7:0]              sw,
  output logic [IO_LED_WIDTH-1:0] led,
  output logic [7:0]              seg0,
  output logic [7:0]              seg1,
  output logic [7:0]              seg_an,
  output logic                    uart_tx
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W = $clog2(SCAN_DIV + 1);
  localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_RELOAD = SC_W'(SCAN_DIV - 1);
  localparam int DISP_LED_W = IO_LED_WIDTH - 9;

  logic [NUM_BTN-1:0] r_btn_s1, r_btn_s2;
  logic [7:0]         r_sw_s1, r_sw_s2;
  logic [NUM_BTN-1:0] r_db_level, r_db_level_d, r_press;
  logic [DB_W-1:0]    r_db_cnt [NUM_BTN];
  logic [31:0]        r_disp;
  logic [SC_W-1:0]    r_scan_cnt;
  logic [SCAN_IDX_W-1:0] r_scan_idx;
  logic [IO_LED_WIDTH-1:0] r_led;
  logic [7:0]         r_seg0, r_seg1, r_seg_an;
  logic               w_uart_busy;
  logic [7:0]         w_pat;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Any sample equal to the accepted level restarts the stability window.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_db_level   <= '0;
      r_db_level_d <= '0;
      r_press      <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_db_cnt[i] <= DB_RELOAD;
    end else begin
      r_db_level_d <= r_db_level;
      r_press      <= r_db_level & ~r_db_level_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_btn_s2[i] == r_db_level[i]) begin
          r_db_cnt[i] <= DB_RELOAD;
        end else if (r_db_cnt[i] == '0) begin
          r_db_level[i] <= r_btn_s2[i];
          r_db_cnt[i]   <= DB_RELOAD;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_disp <= '0;
    end else if (r_press[BTN_C]) begin
      r_disp <= '0;
    end else if (r_press[BTN_U]) begin
      r_disp <= r_disp + 32'd1;
    end else if (r_press[BTN_D]) begin
      r_disp <= r_disp - 32'd1;
    end else if (r_press[BTN_L]) begin
      r_disp <= {r_disp[23:0], r_sw_s2};
    end
  end

`ifdef SOC_UART_EN
  logic w_uart_start;
  assign w_uart_start = r_press[BTN_R] & ~w_uart_busy;

  soc_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(w_uart_start),
    .data (r_sw_s2),
    .tx   (uart_tx),
    .busy (w_uart_busy)
  );
`else
  logic w_unused_btn_r;
  assign w_unused_btn_r = r_press[BTN_R];
  assign w_uart_busy    = 1'b0;
  assign uart_tx        = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_scan_cnt <= SC_RELOAD;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == '0) begin
      r_scan_cnt <= SC_RELOAD;
      r_scan_idx <= r_scan_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt - 1'b1;
    end
  end

  assign w_pat = hex_font(r_disp[{r_scan_idx, 2'b00} +: 4]);

  // Outputs stay 0 during reset; the first post-reset edge already shows digit 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_led    <= '0;
      r_seg0   <= '0;
      r_seg1   <= '0;
      r_seg_an <= '0;
    end else begin
      r_led    <= {w_uart_busy, r_disp[DISP_LED_W-1:0], r_sw_s2};
      r_seg_an <= 8'h01 << r_scan_idx;
      r_seg0   <= r_scan_idx[2] ? 8'h00 : w_pat;
      r_seg1   <= r_scan_idx[2] ? w_pat : 8'h00;
    end
  end

  assign led    = r_led;
  assign seg0   = r_seg0;
  assign seg1   = r_seg1;
  assign seg_an = r_seg_an;

endmodule

// File: tb/tb_soc_top.sv
// Self-checking bench for soc_top with small debounce/scan/baud divisors.
module tb_soc_top;

  localparam int LW = 16;
  localparam int DB = 4;
  localparam int SC = 8;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] btn = '0;
  logic [7:0] sw = '0;
  logic [LW-1:0] led;
  logic [7:0] seg0, seg1, seg_an;
  logic uart_tx;

  soc_top #(
    .IO_LED_WIDTH(LW), .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SC), .BAUD_DIV(BD)
  ) dut (
    .clk(clk), .rst_n(rst), .btn(btn), .sw(sw), .led(led),
    .seg0(seg0), .seg1(seg1), .seg_an(seg_an), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] FONT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                       8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_disp = '0;

  typedef struct {
    logic [4:0]  btn;
    logic [7:0]  sw;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Spec rules: center > up > down > left; right never touches disp.
  task automatic model_apply(input logic [4:0] m, input logic [7:0] s);
    if (m[0]) model_disp = 32'd0;
    else if (m[1]) model_disp = model_disp + 32'd1;
    else if (m[2]) model_disp = model_disp - 32'd1;
    else if (m[3]) model_disp = {model_disp[23:0], s};
  endtask

  task automatic press(input logic [4:0] m);
    btn = m;
    repeat (DB + 10) @(negedge clk);
    btn = '0;
    repeat (DB + 10) @(negedge clk);
  endtask

  // Observe a full scan and rebuild all eight digits from the outputs.
  task automatic check_disp(input string nm, input logic [31:0] exp);
    logic [63:0] obs, expp;
    int other_bad;
    obs = '0;
    other_bad = 0;
    for (int k = 0; k < 8; k++) expp[k*8 +: 8] = FONT[exp[k*4 +: 4]];
    repeat (8 * SC + 2) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        if (seg_an == (8'h01 << k)) begin
          obs[k*8 +: 8] = (k < 4) ? seg0 : seg1;
          if (((k < 4) ? seg1 : seg0) != 8'h00) other_bad++;
        end
      end
    end
    chk({nm, "_digits"}, obs, expp);
    chk({nm, "_otherbank"}, 64'(other_bad), 64'd0);
    chk({nm, "_led_disp"}, 64'(led[LW-2:8]), 64'(exp[LW-10:0]));
  endtask

  vec_t vecs [14];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'b00010, 8'h00, 32'h0000_0001};
    vecs[1]  = '{5'b00010, 8'h00, 32'h0000_0002};
    vecs[2]  = '{5'b00010, 8'h00, 32'h0000_0003};
    vecs[3]  = '{5'b00100, 8'h00, 32'h0000_0002};
    vecs[4]  = '{5'b00100, 8'h00, 32'h0000_0001};
    vecs[5]  = '{5'b00100, 8'h00, 32'h0000_0000};
    vecs[6]  = '{5'b00100, 8'h00, 32'hFFFF_FFFF};
    vecs[7]  = '{5'b00001, 8'h00, 32'h0000_0000};
    vecs[8]  = '{5'b01000, 8'hA5, 32'h0000_00A5};
    vecs[9]  = '{5'b01000, 8'hA5, 32'h0000_A5A5};
    vecs[10] = '{5'b00011, 8'hA5, 32'h0000_0000};
    vecs[11] = '{5'b00110, 8'h11, 32'h0000_0001};
    vecs[12] = '{5'b01100, 8'h22, 32'h0000_0000};
    vecs[13] = '{5'b01000, 8'h3C, 32'h0000_003C};

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_led", 64'(led), 64'd0);
    chk("rst_an", 64'(seg_an), 64'd0);
    chk("rst_seg", 64'({seg0, seg1}), 64'd0);
    chk("rst_tx", 64'(uart_tx), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", 64'(seg_an), 64'h01);
    chk("first_seg0", 64'(seg0), 64'h3F);
    chk("first_seg1", 64'(seg1), 64'h00);

    // Scan sequence over 64+ cycles
    begin
      logic [7:0] prev;
      int run, bad;
      bool_first: begin end
      prev = seg_an; run = 1; bad = 0;
      for (int c = 0; c < 72; c++) begin
        @(negedge clk);
        if (seg_an < 8'h10 && seg1 != 0) bad++;
        if (seg_an >= 8'h10 && seg0 != 0) bad++;
        if (seg_an == prev) run++;
        else begin
          if (seg_an != ((prev == 8'h80) ? 8'h01 : (prev << 1))) bad++;
          if (run != SC && prev != 8'h01) bad++;
          if (prev == 8'h01 && run > SC) bad++;
          prev = seg_an; run = 1;
        end
      end
      chk("scan_seq", 64'(bad), 64'd0);
    end

    // Table vectors
    for (int v = 0; v < 14; v++) begin
      sw = vecs[v].sw;
      press(vecs[v].btn);
      model_apply(vecs[v].btn, vecs[v].sw);
      check_disp($sformatf("vec%0d", v), vecs[v].exp);
      chk($sformatf("vec%0d_led_sw", v), 64'(led[7:0]), 64'(vecs[v].sw));
    end

    // Bounce, then held: exactly one increment
    for (int t = 0; t < 10; t++) begin
      btn[1] = ~btn[1];
      repeat (2) @(negedge clk);
    end
    btn[1] = 1'b1;
    repeat (60) @(negedge clk);
    btn = '0;
    repeat (DB + 10) @(negedge clk);
    model_disp = model_disp + 32'd1;
    check_disp("bounce_hold", model_disp);

    // Randomized presses against the model
    for (int r = 0; r < 16; r++) begin
      logic [4:0] m;
      m = 5'($urandom_range(1, 15));
      sw = 8'($urandom);
      press(m);
      model_apply(m, sw);
      check_disp($sformatf("rand%0d", r), model_disp);
    end

`ifdef SOC_UART_EN
    begin
      logic [9:0] obs;
      int wait_n, busy_bad, extra_zero;
      sw = 8'h5A;
      repeat (4) @(negedge clk);
      btn[4] = 1'b1;
      wait_n = 0;
      while (uart_tx !== 1'b0 && wait_n < 200) begin
        @(negedge clk);
        wait_n++;
      end
      chk("uart_start_seen", 64'(wait_n < 200), 64'd1);
      busy_bad = 0;
      for (int b = 0; b < 10; b++) begin
        if (b == 1) btn = '0;
        if (b == 3) btn[4] = 1'b1;
        if (b == 5) btn = '0;
        repeat ((b == 0) ? 8 : 16) @(negedge clk);
        obs[b] = uart_tx;
        if (led[LW-1] !== 1'b1) busy_bad++;
      end
      chk("uart_frame", 64'(obs), 64'({1'b1, 8'h5A, 1'b0}));
      chk("uart_busy", 64'(busy_bad), 64'd0);
      extra_zero = 0;
      repeat (60) begin
        @(negedge clk);
        if (uart_tx !== 1'b1) extra_zero++;
      end
      chk("uart_drop_second", 64'(extra_zero), 64'd0);
      chk("uart_idle_busy", 64'(led[LW-1]), 64'd0);
      check_disp("uart_disp_kept", model_disp);
      // Reset mid-frame
      btn[4] = 1'b1;
      repeat (DB + 8 + 3 * BD) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("uart_rst_tx", 64'(uart_tx), 64'd1);
      btn = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_disp = '0;
      repeat (4) @(negedge clk);
      chk("uart_post_rst_tx", 64'(uart_tx), 64'd1);
    end
`else
    begin
      int zeros, busy_bad;
      zeros = 0; busy_bad = 0;
      btn[4] = 1'b1;
      repeat (100) begin
        @(negedge clk);
        if (uart_tx !== 1'b1) zeros++;
        if (led[LW-1] !== 1'b0) busy_bad++;
      end
      btn = '0;
      chk("notx_line", 64'(zeros), 64'd0);
      chk("notx_busy", 64'(busy_bad), 64'd0);
      check_disp("notx_disp_kept", model_disp);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
